// File: rtl/deserializador_32_if.sv
// Serial input, word output and overflow signals of the 32-bit deserializer.
// master drives the serial side and consumes words; slave is the deserializer.
interface deserializador_32_if;
  logic        S_IN;
  logic        S_VAL;
  logic        DIR;
  logic        SOF;
  logic [31:0] Q;
  logic        Q_VAL;
  logic        Q_RDY;
  logic        OVF;
  logic        CLR_OVF;
  logic [4:0]  BIT_CNT;

  modport master (
    output S_IN, S_VAL, DIR, SOF, Q_RDY, CLR_OVF,
    input  Q, Q_VAL, OVF, BIT_CNT
  );

  modport slave (
    input  S_IN, S_VAL, DIR, SOF, Q_RDY, CLR_OVF,
    output Q, Q_VAL, OVF, BIT_CNT
  );
endinterface

// File: rtl/deserializador_32.sv
// Serial-to-parallel receiver: assembles 32-bit words from the shifter's serial
// output into a one-entry valid/ready holding register with sticky overflow.
//
// state | meaning
// IDLE  | cnt = 0, no partial word; next valid bit starts a word
// RECV  | 1..31 bits of the current word collected
module deserializador_32 (
  input logic                CLK,
  input logic                RST_L,
  deserializador_32_if.slave bus
);
  localparam int ANCHO = 32;

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, stateNext;
  logic [ANCHO-1:0] acum, acumNext;
  logic [4:0]       cnt, cntNext;
  logic             dirW, dirWNext;
  logic [ANCHO-1:0] qReg, qNext;
  logic             qVal, qValNext;
  logic             ovf, ovfNext;

  logic             firstBit;
  logic             useDir;
  logic             wordDone;
  logic             ovfSet;
  logic [ANCHO-1:0] base;
  logic [4:0]       cntBase;

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state <= IDLE;
      acum  <= '0;
      cnt   <= '0;
      dirW  <= 1'b0;
      qReg  <= '0;
      qVal  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= stateNext;
      acum  <= acumNext;
      cnt   <= cntNext;
      dirW  <= dirWNext;
      qReg  <= qNext;
      qVal  <= qValNext;
      ovf   <= ovfNext;
    end
  end

  always_comb begin
    stateNext = state;
    acumNext  = acum;
    cntNext   = cnt;
    dirWNext  = dirW;
    qNext     = qReg;
    qValNext  = qVal;
    wordDone  = 1'b0;
    ovfSet    = 1'b0;

    // SOF restarts the word, so direction is resampled and the partial is dropped
    firstBit = (state == IDLE) || bus.SOF;
    useDir   = firstBit ? bus.DIR : dirW;
    base     = bus.SOF ? '0 : acum;
    cntBase  = bus.SOF ? 5'd0 : cnt;

    if (bus.S_VAL) begin
      if (firstBit) dirWNext = bus.DIR;
      acumNext = useDir ? {base[ANCHO-2:0], bus.S_IN} : {bus.S_IN, base[ANCHO-1:1]};
      if (cntBase == 5'd31) begin
        wordDone  = 1'b1;
        cntNext   = 5'd0;
        stateNext = IDLE;
      end else begin
        cntNext   = cntBase + 5'd1;
        stateNext = RECV;
      end
    end

    // A consumer taking Q in the completion cycle frees the slot for the new word
    if (wordDone) begin
      if (!qVal || bus.Q_RDY) begin
        qNext    = acumNext;
        qValNext = 1'b1;
      end else begin
        ovfSet = 1'b1;
      end
    end else if (qVal && bus.Q_RDY) begin
      qValNext = 1'b0;
    end

    ovfNext = ovfSet ? 1'b1 : (bus.CLR_OVF ? 1'b0 : ovf);
  end

  assign bus.Q       = qReg;
  assign bus.Q_VAL   = qVal;
  assign bus.OVF     = ovf;
  assign bus.BIT_CNT = cnt;
endmodule

// File: tb/tb_deserializador_32.sv
// Directed and randomized bench for deserializador_32 against a bit-queue model.
module tb_deserializador_32;
  logic CLK = 1'b0;
  logic RST_L;
  int   checks = 0;
  int   errors = 0;

  deserializador_32_if bus();
  deserializador_32 dut (.CLK(CLK), .RST_L(RST_L), .bus(bus.slave));

  always #5 CLK = ~CLK;

  // Observed outputs packed as {Q, Q_VAL, OVF, BIT_CNT}
  wire [38:0] obs = {bus.Q, bus.Q_VAL, bus.OVF, bus.BIT_CNT};

  // Reference model: list of bits received so far plus the holding slot
  bit          mBits[$];
  bit          mDir;
  logic [31:0] mQ;
  bit          mQVal;
  bit          mOvf;

  function automatic logic [38:0] model_vec();
    return {mQ, mQVal, mOvf, 5'(mBits.size())};
  endfunction

  task automatic model_update(input bit rstL, input bit sval, input bit sin, input bit dir,
                              input bit sof, input bit rdy, input bit clr);
    logic [31:0] w;
    bit done;
    bit lose;
    done = 0;
    lose = 0;
    w = '0;
    if (!rstL) begin
      mBits.delete();
      mDir = 0; mQ = '0; mQVal = 0; mOvf = 0;
      return;
    end
    if (sval) begin
      if (sof) mBits.delete();
      if (mBits.size() == 0) mDir = dir;
      mBits.push_back(sin);
      if (mBits.size() == 32) begin
        // k-th received bit lands at bit 31-k when MSB first, bit k when LSB first
        for (int k = 0; k < 32; k++) begin
          if (mDir) w[31-k] = mBits[k];
          else      w[k]    = mBits[k];
        end
        mBits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!mQVal || rdy) begin mQ = w; mQVal = 1; end
      else lose = 1;
    end else if (mQVal && rdy) mQVal = 0;
    if (lose) mOvf = 1;
    else if (clr) mOvf = 0;
  endtask

  task automatic cycle(input bit rstL, input bit sval, input bit sin, input bit dir,
                       input bit sof, input bit rdy, input bit clr);
    RST_L = rstL; bus.S_VAL = sval; bus.S_IN = sin; bus.DIR = dir;
    bus.SOF = sof; bus.Q_RDY = rdy; bus.CLR_OVF = clr;
    @(posedge CLK);
    model_update(rstL, sval, sin, dir, sof, rdy, clr);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input bit d, input bit sofFirst,
                           input bit rdy, input int first, input int last);
    for (int i = first; i <= last; i++)
      cycle(1, 1, d ? w[31-i] : w[i], d, sofFirst && (i == first), rdy, 0);
  endtask

  task automatic idle(input bit rdy, input bit clr);
    cycle(1, 0, 0, 0, 0, rdy, clr);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 1, 0);
    checks++;
    if (obs !== 39'd0) begin
      errors++; $display("FAIL reset: got %h required %h", obs, 39'd0);
    end
  endtask

  task automatic test_msb_word();
    send_bits(32'hA5C3_0F81, 1, 1, 0, 0, 31);
    checks++;
    if (obs !== {32'hA5C3_0F81, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL msb_word: got %h required %h", obs, {32'hA5C3_0F81, 1'b1, 1'b0, 5'd0});
    end
    idle(1, 0);
    checks++;
    if (obs !== {32'hA5C3_0F81, 1'b0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL msb_consume: got %h required %h", obs, {32'hA5C3_0F81, 1'b0, 1'b0, 5'd0});
    end
  endtask

  task automatic test_lsb_word();
    logic [31:0] w;
    w = 32'h1234_5678;
    for (int i = 0; i < 32; i++) cycle(1, 1, w[i], i > 5, 0, 0, 0);
    checks++;
    if (obs !== {w, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL lsb_word: got %h required %h", obs, {w, 1'b1, 1'b0, 5'd0});
    end
    idle(1, 0);
  endtask

  task automatic test_gap_sof();
    logic [31:0] junk;
    junk = $urandom;
    send_bits(junk, 1, 0, 0, 0, 4);
    repeat (3) idle(0, 0);
    send_bits(junk, 1, 0, 0, 5, 9);
    checks++;
    if (obs !== {32'h1234_5678, 1'b0, 1'b0, 5'd10}) begin
      errors++; $display("FAIL gap_count: got %h required %h", obs, {32'h1234_5678, 1'b0, 1'b0, 5'd10});
    end
    send_bits(32'hDEAD_BEEF, 1, 1, 0, 0, 30);
    checks++;
    if (obs !== {32'h1234_5678, 1'b0, 1'b0, 5'd31}) begin
      errors++; $display("FAIL sof_no_partial: got %h required %h", obs, {32'h1234_5678, 1'b0, 1'b0, 5'd31});
    end
    send_bits(32'hDEAD_BEEF, 1, 0, 0, 31, 31);
    checks++;
    if (obs !== {32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL sof_word: got %h required %h", obs, {32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0});
    end
    idle(1, 0);
  endtask

  task automatic test_overflow();
    send_bits(32'h0000_0001, 1, 0, 0, 0, 31);
    send_bits(32'hFFFF_FFFF, 0, 0, 0, 0, 31);
    checks++;
    if (obs !== {32'h0000_0001, 1'b1, 1'b1, 5'd0}) begin
      errors++; $display("FAIL ovf_set: got %h required %h", obs, {32'h0000_0001, 1'b1, 1'b1, 5'd0});
    end
    repeat (5) idle(0, 0);
    checks++;
    if (bus.OVF !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b required 1", bus.OVF);
    end
    // third lost word with CLR_OVF on the same edge: set must win
    send_bits(32'h0F0F_0F0F, 1, 0, 0, 0, 30);
    cycle(1, 1, 1'b1, 1, 0, 0, 1);
    checks++;
    if (obs !== {32'h0000_0001, 1'b1, 1'b1, 5'd0}) begin
      errors++; $display("FAIL ovf_set_wins: got %h required %h", obs, {32'h0000_0001, 1'b1, 1'b1, 5'd0});
    end
    idle(0, 1);
    checks++;
    if (obs !== {32'h0000_0001, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL ovf_clear: got %h required %h", obs, {32'h0000_0001, 1'b1, 1'b0, 5'd0});
    end
    idle(1, 0);
  endtask

  task automatic test_simul();
    send_bits(32'h0000_00AA, 1, 0, 0, 0, 31);
    send_bits(32'h0000_0055, 1, 0, 0, 0, 30);
    checks++;
    if (obs !== {32'h0000_00AA, 1'b1, 1'b0, 5'd31}) begin
      errors++; $display("FAIL simul_hold: got %h required %h", obs, {32'h0000_00AA, 1'b1, 1'b0, 5'd31});
    end
    send_bits(32'h0000_0055, 1, 0, 1, 31, 31);
    checks++;
    if (obs !== {32'h0000_0055, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL simul_pass: got %h required %h", obs, {32'h0000_0055, 1'b1, 1'b0, 5'd0});
    end
    idle(1, 0);
  endtask

  task automatic test_reset_midword();
    logic [31:0] w;
    bit d;
    w = $urandom;
    send_bits(w, 1, 0, 0, 0, 19);
    checks++;
    if (bus.BIT_CNT !== 5'd20) begin
      errors++; $display("FAIL rst_pre_count: got %0d required 20", bus.BIT_CNT);
    end
    cycle(0, 1, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== 39'd0) begin
      errors++; $display("FAIL rst_midword: got %h required %h", obs, 39'd0);
    end
    w = $urandom;
    d = 1'($urandom_range(0, 1));
    send_bits(w, d, 0, 0, 0, 0);
    checks++;
    if (obs !== {32'd0, 1'b0, 1'b0, 5'd1}) begin
      errors++; $display("FAIL rst_first_bit: got %h required %h", obs, {32'd0, 1'b0, 1'b0, 5'd1});
    end
    send_bits(w, d, 0, 0, 1, 31);
    checks++;
    if (obs !== {w, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL rst_fresh_word: got %h required %h", obs, {w, 1'b1, 1'b0, 5'd0});
    end
    // reset on the completing edge with Q full: word lost, no overflow
    send_bits(w, d, 0, 0, 0, 30);
    cycle(0, 1, 0, d, 0, 0, 0);
    checks++;
    if (obs !== 39'd0) begin
      errors++; $display("FAIL rst_on_complete: got %h required %h", obs, 39'd0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) < 8,
            1'($urandom),
            1'($urandom),
            $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h required %h", n, obs, model_vec());
      end
    end
  endtask

  initial begin
    RST_L = 0; bus.S_IN = 0; bus.S_VAL = 0; bus.DIR = 0;
    bus.SOF = 0; bus.Q_RDY = 0; bus.CLR_OVF = 0;
    test_reset();
    test_msb_word();
    test_lsb_word();
    test_gap_sof();
    test_overflow();
    test_simul();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
